// File: rtl/ram_fifo_ctrl_if.sv
// Handshake and RAM-control bundle for ram_fifo_ctrl.
// slave = the controller, master = stream source/sink plus the RAM model.
interface ram_fifo_ctrl_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic [ADDR_W:0]   count;
   logic              ram_we;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   modport slave (
      input  in_valid, in_data, out_ready, ram_dout,
      output in_ready, out_valid, out_data, count,
             ram_we, ram_re, ram_addr, ram_din
   );

   modport master (
      output in_valid, in_data, out_ready, ram_dout,
      input  in_ready, out_valid, out_data, count,
             ram_we, ram_re, ram_addr, ram_din
   );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for a single-port synchronous RAM: arbitrates one write or
// one read per cycle onto the shared address bus and prefetches one word.
module ram_fifo_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DEPTH  = 16
) (
   input logic            clk,
   input logic            rst_n,
   ram_fifo_ctrl_if.slave bus
);
   typedef enum logic {PRIO_RD = 1'b0, PRIO_WR = 1'b1} prio_e;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              out_valid_q, out_valid_d;
   prio_e             prio_q, prio_d;

   logic full, empty, rd_want, wr_want, conflict, rd_issue, wr_issue;

   always_comb begin
      full     = (count_q == FULL_CNT);
      empty    = (count_q == '0);
      rd_want  = !empty && (!out_valid_q || bus.out_ready);
      wr_want  = bus.in_valid && !full;
      conflict = rd_want && wr_want;
      // rst_n gating keeps the RAM strobes quiet while reset is asserted
      rd_issue = rst_n && rd_want && (!wr_want || (prio_q == PRIO_RD));
      wr_issue = rst_n && wr_want && (!rd_want || (prio_q == PRIO_WR));
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      prio_d      = prio_q;
      if (wr_issue) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         count_d  = count_q + (ADDR_W+1)'(1);
      end
      if (rd_issue) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         count_d  = count_q - (ADDR_W+1)'(1);
      end
      if (rd_issue) begin
         out_valid_d = 1'b1;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      if (conflict) begin
         prio_d = (prio_q == PRIO_RD) ? PRIO_WR : PRIO_RD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         prio_q      <= PRIO_RD;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         prio_q      <= prio_d;
      end
   end

   assign bus.ram_re    = rd_issue;
   assign bus.ram_we    = wr_issue;
   assign bus.ram_addr  = rd_issue ? rd_ptr_q : wr_ptr_q;
   assign bus.ram_din   = bus.in_data;
   assign bus.in_ready  = rst_n && !full && !rd_issue;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = bus.ram_dout;
   assign bus.count     = count_q;
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Upstream controller for the single-port `sync_ram` (16 x 8). It turns a valid/ready write stream and a valid/ready read stream into the RAM's `we`/`re`/`addr`/`din` controls, so the RAM behaves as a FIFO.
- The RAM has one shared address bus, so a write and a read cannot both issue in the same cycle. This block arbitrates between them.
- Read data is returned from the RAM's registered `dout`.

Parameters:
- DATA_W, 8, data width; matches RAM `din`/`dout`.
- ADDR_W, 4, RAM address width.
- DEPTH, 16, RAM word count; equals 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  write-side data valid.
- in_data  in  DATA_W  write-side data.
- in_ready  out  1  write accepted this cycle when in_valid && in_ready.
- out_valid  out  1  out_data holds the oldest unconsumed word.
- out_data  out  DATA_W  read data; wired directly from ram_dout.
- out_ready  in  1  consumer takes the word when out_valid && out_ready.
- count  out  ADDR_W+1  words in RAM not yet read-issued (0..DEPTH).
- ram_we  out  1  to RAM `we`.
- ram_re  out  1  to RAM `re`.
- ram_addr  out  ADDR_W  to RAM `addr`.
- ram_din  out  DATA_W  to RAM `din`.
- ram_dout  in  DATA_W  from RAM `dout`. Registered in the RAM on the edge where re=1; held when re=0; unaffected by writes.

Behaviour:
- State registers: wr_ptr, rd_ptr (ADDR_W each), count, out_valid, prio (0 = read favoured, 1 = write favoured).
- Reset (rst_n low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, out_valid=0, prio=0.
  - in_ready, ram_we and ram_re are forced to 0 combinationally while rst_n is low.
  - RAM contents are not cleared.
- Request terms (combinational):
  - rd_want = (count!=0) && (!out_valid || out_ready).
  - wr_want = in_valid && (count!=DEPTH).
- Arbitration:
  - Only one requester: it is granted.
  - Both request (conflict): grant read if prio=0, write if prio=1; prio toggles on every conflict cycle only.
- Issue outputs:
  - rd_issue = rd_want && granted; wr_issue = wr_want && granted.
  - ram_re = rd_issue; ram_we = wr_issue; ram_din = in_data.
  - ram_addr = rd_issue ? rd_ptr : wr_ptr.
- in_ready = (count!=DEPTH) && !rd_issue. It is combinational and depends on out_ready; this is accepted.
- On a clock edge:
  - wr_issue: wr_ptr+1, wrapping DEPTH-1 to 0.
  - rd_issue: rd_ptr+1, wrapping DEPTH-1 to 0.
  - count: +1 on wr_issue, -1 on rd_issue; never both in one cycle.
- out_valid next state:
  - 1 if rd_issue.
  - else 0 if out_ready.
  - else hold.
- Read latency: word read-issued on edge k is valid on out_data/out_valid after edge k.
  - Reissuing while out_valid && out_ready gives 1 word/cycle on the read side.
- One-word prefetch: a read issues whenever out_valid=0 and count>0, even with out_ready=0. Total capacity is therefore DEPTH+1 words: DEPTH in RAM plus 1 in the RAM output register.
- Boundary conditions:
  - count==0: no read issues; out_valid drops after consumption.
  - count==DEPTH: in_ready=0; a write issues only after a read decrements count.
  - Pointer wrap is by natural ADDR_W overflow; order is preserved across the wrap.
  - in_valid while in_ready=0: no effect; the source holds its data.
  - Reset mid-operation: all state clears immediately. Stale ram_dout is ignored because out_valid=0. After release, the first write goes to address 0.

Test Plan:
- Reset: rst_n low 3 cycles, then high, in_valid=0 -> count=0, out_valid=0, in_ready=1, ram_we=ram_re=0.
- Write 55,100,200 back-to-back (in_valid held), out_ready=0 ->
  - cycle0 write 55 at addr 1? no: at addr 0.
  - cycle1 conflict: read of addr 0 wins, in_ready=0.
  - cycle2 write 100 at addr 1; cycle3 write 200 at addr 2.
  - End state: out_valid=1, out_data=55, count=2.
- Fill: out_ready=0, push 0..17 -> 17 words accepted (0..16), then in_ready=0 with count=16. Raise out_ready -> outputs 0,1,2,... in order; in_ready returns 1 once count<16.
- Streaming: in_valid=1 and out_ready=1 continuously -> every conflict grant alternates read/write; no word lost or duplicated over 50 words.
- Wrap: push/pop 0..39 with random valid/ready gaps -> output sequence 0..39 exactly; wr_ptr/rd_ptr pass 15->0 twice.
- Reset mid-operation: with count=5 and out_valid=1, pull rst_n low between edges -> out_valid, ram_we, ram_re go 0 immediately. After release, count=0; next push writes addr 0 and pops return only new data.
